vr_source: RTL and testbench

Transmitting end of the `valid_ready` protocol. Generates a programmable-length stream of data words on a `valid_ready.Master` port, inserting a programmable idle gap after every accepted word. It pairs with the bus sink in workshop testbenches to exercise back-pressure and stall behaviour from the driving side.

---
 rtl/vr_source_pkg.sv | 29 ++
 rtl/vr_source_if.sv | 15 +
 rtl/vr_source_lfsr.sv | 40 ++++
 rtl/vr_source.sv | 154 +++++++++++++++
 tb/tb_vr_source.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/vr_source_pkg.sv
// vr_source_pkg -- shared types and constants for the vr_source block.
//   state_e        : source FSM states (IDLE, DELAY, OFFER, DONE)
//   LFSR_TAPS_*    : Fibonacci LFSR feedback masks for 8/16/32-bit data
//   lfsr_taps()    : selects the mask for a given data width (0 if unsupported)
package vr_source_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DELAY = 2'd1,
    OFFER = 2'd2,
    DONE  = 2'd3
  } state_e;

  // Bit i set = bit i of the register feeds the XOR. Maximal-length taps:
  // 8: x^8+x^6+x^5+x^4+1, 16: x^16+x^15+x^13+x^4+1, 32: x^32+x^22+x^2+x+1.
  localparam logic [31:0] LFSR_TAPS_8  = 32'h0000_00B8;
  localparam logic [31:0] LFSR_TAPS_16 = 32'h0000_D008;
  localparam logic [31:0] LFSR_TAPS_32 = 32'h8020_0003;

  function automatic logic [31:0] lfsr_taps(input int width);
    case (width)
      8:       return LFSR_TAPS_8;
      16:      return LFSR_TAPS_16;
      32:      return LFSR_TAPS_32;
      default: return 32'h0;
    endcase
  endfunction

endpackage

// File: rtl/vr_source_if.sv
// valid_ready -- single-direction valid/ready handshake bus.
//   valid : word on data is offered (Master -> Slave)
//   data  : payload, DATA_WIDTH bits (Master -> Slave)
//   ready : Slave can accept this cycle (Slave -> Master)
// A word transfers on any rising edge where valid && ready.
interface valid_ready #(
  parameter int DATA_WIDTH = 8
);
  logic                  valid;
  logic                  ready;
  logic [DATA_WIDTH-1:0] data;

  modport Master (output valid, output data, input  ready);
  modport Slave  (input  valid, input  data, output ready);
endinterface

// File: rtl/vr_source_lfsr.sv
// vr_source_lfsr -- Fibonacci LFSR data generator (used when
// VR_SOURCE_LFSR_EN is defined).
//   clk, reset : clock and synchronous active-high reset (value -> 0)
//   load       : load seed (a zero seed is replaced with 1, since all-zero
//                is the lock-up state of an XOR LFSR)
//   step       : advance one step (shift left, feedback into bit 0)
//   seed       : load value
//   value      : current register contents
module vr_source_lfsr
  import vr_source_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             step,
  input  logic [WIDTH-1:0] seed,
  output logic [WIDTH-1:0] value
);

  localparam logic [WIDTH-1:0] TAPS = WIDTH'(lfsr_taps(WIDTH));

  logic [WIDTH-1:0] value_q;
  logic             feedback;

  assign feedback = ^(value_q & TAPS);
  assign value    = value_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      value_q <= '0;
    end else if (load) begin
      value_q <= (seed == '0) ? WIDTH'(1) : seed;
    end else if (step) begin
      value_q <= {value_q[WIDTH-2:0], feedback};
    end
  end

endmodule

// File: rtl/vr_source.sv
// vr_source -- transmitting end of the valid_ready protocol.
// Emits num_words words (0 = unlimited) starting at start_value, with
// `delay` idle cycles before each word. Optional macro VR_SOURCE_LFSR_EN
// replaces the incrementing data with a maximal-length LFSR sequence.
//   clk         : clock, rising edge
//   reset       : synchronous, active-high
//   enable      : start / continue request
//   delay       : idle cycles inserted before each word
//   num_words   : words per burst, 0 = unlimited
//   start_value : first data word / LFSR seed
//   done        : burst complete (set on final handshake, cleared on start)
//   sent_count  : handshakes completed in the current burst
//   vrBus       : valid_ready Master port (valid, data out; ready in)
module vr_source
  import vr_source_pkg::*;
#(
  parameter int DATA_WIDTH = 8,
  parameter int DELAY_BITS = 3,
  parameter int COUNT_BITS = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  enable,
  input  logic [DELAY_BITS-1:0] delay,
  input  logic [COUNT_BITS-1:0] num_words,
  input  logic [DATA_WIDTH-1:0] start_value,
  output logic                  done,
  output logic [COUNT_BITS-1:0] sent_count,
  valid_ready.Master            vrBus
);

  state_e                state_q, state_d;
  logic [DELAY_BITS-1:0] delay_q;
  logic [DELAY_BITS-1:0] dcnt_q;
  logic [COUNT_BITS-1:0] sent_count_q;
  logic                  done_q;

  logic handshake;   // word accepted on this edge
  logic last_word;   // this handshake completes a bounded burst
  logic load;        // burst start: capture start_value, clear counters
  logic relatch;     // capture delay for the next word

  // valid is a pure state decode, so ready never reaches it combinationally.
  assign vrBus.valid = (state_q == OFFER);
  assign handshake   = (state_q == OFFER) && vrBus.ready;
  assign last_word   = (num_words != '0) &&
                       ((sent_count_q + COUNT_BITS'(1)) == num_words);
  assign done        = done_q;
  assign sent_count  = sent_count_q;

  // NOTE: every output of this block is given a default first; without it,
  // any path that skips an assignment would infer a latch.
  always_comb begin
    state_d = state_q;
    load    = 1'b0;
    relatch = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable) begin
          load    = 1'b1;
          state_d = (delay == '0) ? OFFER : DELAY;
        end
      end
      DELAY: begin
        if (!enable) begin
          state_d = IDLE;
        end else if ((dcnt_q + DELAY_BITS'(1)) == delay_q) begin
          state_d = OFFER;
        end
      end
      OFFER: begin
        // Dropping enable here does not withdraw the offer; it only takes
        // effect once the pending word has been accepted.
        if (handshake) begin
          if (last_word) begin
            state_d = DONE;
          end else if (!enable) begin
            state_d = IDLE;
          end else begin
            relatch = 1'b1;
            state_d = (delay == '0) ? OFFER : DELAY;
          end
        end
      end
      DONE: begin
        if (!enable) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= IDLE;
      delay_q      <= '0;
      dcnt_q       <= '0;
      sent_count_q <= '0;
      done_q       <= 1'b0;
    end else begin
      state_q <= state_d;

      if (load || relatch) begin
        delay_q <= delay;
        dcnt_q  <= '0;
      end else if (state_q == DELAY) begin
        dcnt_q  <= dcnt_q + DELAY_BITS'(1);
      end

      if (load) begin
        sent_count_q <= '0;
        done_q       <= 1'b0;
      end else if (handshake) begin
        sent_count_q <= sent_count_q + COUNT_BITS'(1);  // wraps when unlimited
        if (last_word) done_q <= 1'b1;
      end
    end
  end

`ifdef VR_SOURCE_LFSR_EN
  logic [DATA_WIDTH-1:0] lfsr_value;

  vr_source_lfsr #(
    .WIDTH (DATA_WIDTH)
  ) u_lfsr (
    .clk   (clk),
    .reset (reset),
    .load  (load),
    .step  (handshake),
    .seed  (start_value),
    .value (lfsr_value)
  );

  assign vrBus.data = lfsr_value;
`else
  logic [DATA_WIDTH-1:0] data_q;

  // data only changes on load (not in OFFER) or on handshake, so it is
  // stable for as long as valid is held without ready.
  always_ff @(posedge clk) begin
    if (reset) begin
      data_q <= '0;
    end else if (load) begin
      data_q <= start_value;
    end else if (handshake) begin
      data_q <= data_q + DATA_WIDTH'(1);
    end
  end

  assign vrBus.data = data_q;
`endif

endmodule

// File: tb/tb_vr_source.sv
// tb_vr_source -- directed, table-driven bench for vr_source (8/3/8 config).
// Each table row is applied before a rising edge; outputs are compared 1 ns
// after that edge. Hand-written sequences follow for counter wrap and (when
// VR_SOURCE_LFSR_EN is defined) the LFSR sequence.
module tb_vr_source;

  logic       clk = 1'b0;
  logic       reset;
  logic       enable;
  logic [2:0] delay;
  logic [7:0] num_words;
  logic [7:0] start_value;
  logic       done;
  logic [7:0] sent_count;

  int n_checks = 0;
  int n_errors = 0;

  valid_ready #(.DATA_WIDTH(8)) bus ();

  vr_source #(
    .DATA_WIDTH (8),
    .DELAY_BITS (3),
    .COUNT_BITS (8)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .delay       (delay),
    .num_words   (num_words),
    .start_value (start_value),
    .done        (done),
    .sent_count  (sent_count),
    .vrBus       (bus.Master)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       en;
    logic [2:0] dly;
    logic [7:0] nw;
    logic [7:0] sv;
    logic       rdy;
    logic       e_valid;
    logic [7:0] e_data;
    logic       e_done;
    logic       care_done;
    logic [7:0] e_cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic rst, input logic en, input logic [2:0] dly,
                       input logic [7:0] nw, input logic [7:0] sv,
                       input logic rdy);
    reset       = rst;
    enable      = en;
    delay       = dly;
    num_words   = nw;
    start_value = sv;
    bus.ready   = rdy;
  endtask

  initial begin
    logic saw_done;

    drive(1'b1, 1'b0, 3'd0, 8'd0, 8'h00, 1'b0);

    //                rst en dly nw     sv     rdy | valid data  done cd cnt
    // reset
    vecs.push_back('{1'b1,1'b0,3'd0,8'd0,8'h00,1'b0, 1'b0,8'h00,1'b0,1'b1,8'd0});
    // delay 0, 4 words from FE, ready held: FE FF 00 01 then done
    vecs.push_back('{1'b0,1'b1,3'd0,8'd4,8'hFE,1'b1, 1'b1,8'hFE,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b1,3'd0,8'd4,8'hFE,1'b1, 1'b1,8'hFF,1'b0,1'b1,8'd1});
    vecs.push_back('{1'b0,1'b1,3'd0,8'd4,8'hFE,1'b1, 1'b1,8'h00,1'b0,1'b1,8'd2});
    vecs.push_back('{1'b0,1'b1,3'd0,8'd4,8'hFE,1'b1, 1'b1,8'h01,1'b0,1'b1,8'd3});
    vecs.push_back('{1'b0,1'b1,3'd0,8'd4,8'hFE,1'b1, 1'b0,8'h02,1'b1,1'b1,8'd4});
    vecs.push_back('{1'b0,1'b0,3'd0,8'd4,8'hFE,1'b1, 1'b0,8'h02,1'b0,1'b0,8'd4});
    // delay 3, 2 words: low 3, high 1, low 3, high 1, done
    vecs.push_back('{1'b0,1'b1,3'd3,8'd2,8'h10,1'b1, 1'b0,8'h10,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b1,3'd3,8'd2,8'h10,1'b1, 1'b0,8'h10,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b1,3'd3,8'd2,8'h10,1'b1, 1'b0,8'h10,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b1,3'd3,8'd2,8'h10,1'b1, 1'b1,8'h10,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b1,3'd3,8'd2,8'h10,1'b1, 1'b0,8'h11,1'b0,1'b1,8'd1});
    vecs.push_back('{1'b0,1'b1,3'd3,8'd2,8'h10,1'b1, 1'b0,8'h11,1'b0,1'b1,8'd1});
    vecs.push_back('{1'b0,1'b1,3'd3,8'd2,8'h10,1'b1, 1'b0,8'h11,1'b0,1'b1,8'd1});
    vecs.push_back('{1'b0,1'b1,3'd3,8'd2,8'h10,1'b1, 1'b1,8'h11,1'b0,1'b1,8'd1});
    vecs.push_back('{1'b0,1'b1,3'd3,8'd2,8'h10,1'b1, 1'b0,8'h12,1'b1,1'b1,8'd2});
    vecs.push_back('{1'b0,1'b0,3'd3,8'd2,8'h10,1'b1, 1'b0,8'h12,1'b0,1'b0,8'd2});
    // stall with ready low; enable dropped mid-offer; ready ignored when idle
    vecs.push_back('{1'b0,1'b1,3'd0,8'd0,8'h40,1'b0, 1'b1,8'h40,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b0,3'd0,8'd0,8'h40,1'b0, 1'b1,8'h40,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b0,3'd0,8'd0,8'h40,1'b1, 1'b0,8'h41,1'b0,1'b1,8'd1});
    vecs.push_back('{1'b0,1'b0,3'd0,8'd0,8'h40,1'b1, 1'b0,8'h41,1'b0,1'b1,8'd1});
    // enable dropped during DELAY aborts before the offer would start
    vecs.push_back('{1'b0,1'b1,3'd2,8'd0,8'h77,1'b1, 1'b0,8'h77,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b0,3'd2,8'd0,8'h77,1'b1, 1'b0,8'h77,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b0,3'd2,8'd0,8'h77,1'b1, 1'b0,8'h77,1'b0,1'b1,8'd0});
    // reset asserted mid-offer
    vecs.push_back('{1'b0,1'b1,3'd0,8'd0,8'h90,1'b0, 1'b1,8'h90,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b1,3'd0,8'd0,8'h90,1'b1, 1'b1,8'h91,1'b0,1'b1,8'd1});
    vecs.push_back('{1'b1,1'b1,3'd0,8'd0,8'h90,1'b0, 1'b0,8'h00,1'b0,1'b1,8'd0});
    vecs.push_back('{1'b0,1'b0,3'd0,8'd0,8'h90,1'b0, 1'b0,8'h00,1'b0,1'b1,8'd0});

    #2;
    for (int i = 0; i < vecs.size(); i++) begin
      drive(vecs[i].rst, vecs[i].en, vecs[i].dly, vecs[i].nw, vecs[i].sv,
            vecs[i].rdy);
      tick();
      check($sformatf("row%0d valid", i), 32'(bus.valid), 32'(vecs[i].e_valid));
`ifndef VR_SOURCE_LFSR_EN
      check($sformatf("row%0d data", i), 32'(bus.data), 32'(vecs[i].e_data));
`endif
      check($sformatf("row%0d sent_count", i), 32'(sent_count),
            32'(vecs[i].e_cnt));
      if (vecs[i].care_done)
        check($sformatf("row%0d done", i), 32'(done), 32'(vecs[i].e_done));
    end

    // Unlimited mode, full throughput: after k edges in OFFER, k words sent.
    drive(1'b0, 1'b1, 3'd0, 8'd0, 8'h00, 1'b1);
    tick();
    check("wrap start valid", 32'(bus.valid), 32'd1);
    check("wrap start count", 32'(sent_count), 32'd0);
    saw_done = 1'b0;
    for (int k = 1; k <= 300; k++) begin
      tick();
      if (done) saw_done = 1'b1;
      if (k == 255) check("wrap count 255", 32'(sent_count), 32'd255);
      if (k == 256) begin
        check("wrap count 0", 32'(sent_count), 32'd0);
        check("wrap valid", 32'(bus.valid), 32'd1);
`ifndef VR_SOURCE_LFSR_EN
        check("wrap data 0", 32'(bus.data), 32'd0);
`endif
      end
      if (k == 300) begin
        check("wrap count 44", 32'(sent_count), 32'd44);
`ifndef VR_SOURCE_LFSR_EN
        check("wrap data 44", 32'(bus.data), 32'h2C);
`endif
      end
    end
    check("wrap done never set", 32'(saw_done), 32'd0);

`ifdef VR_SOURCE_LFSR_EN
    // Zero seed becomes 1; taps 0xB8 give 01 02 04 08 10 21.
    begin
      logic [7:0] lfsr_exp [6];
      lfsr_exp = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h21};
      drive(1'b1, 1'b0, 3'd0, 8'd0, 8'h00, 1'b0);
      tick();
      drive(1'b0, 1'b1, 3'd0, 8'd0, 8'h00, 1'b0);
      tick();
      check("lfsr seed0", 32'(bus.data), 32'(lfsr_exp[0]));
      bus.ready = 1'b1;
      for (int j = 1; j < 6; j++) begin
        tick();
        check($sformatf("lfsr step%0d", j), 32'(bus.data), 32'(lfsr_exp[j]));
      end
    end
`endif

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
